// File: rtl/bcd_convert_sequencer.sv
// Converts a 21-bit signed result into six packed BCD digits plus sign and
// overflow flags, using a fixed-latency serial double-dabble sequence.
//
// state | meaning
// IDLE  | waiting for start; value captured on the accepting edge
// LOAD  | magnitude/sign/overflow derived, shift register and counter cleared
// SHIFT | one double-dabble step per cycle, 20 steps total
// DONE  | outputs loaded and done pulsed on the exit edge
module bcd_convert_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [20:0] value,
    output logic        busy,
    output logic        done,
    output logic [23:0] BCD,
    output logic        signBit,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t      state;
    logic [20:0] value_q;
    logic [19:0] mag;
    logic [23:0] bcd_sr;
    logic [4:0]  cnt;
    logic        sign_q;
    logic        ovf_q;

    logic [20:0] mag_full;
    logic        ovf_c;
    logic [23:0] bcd_adj;

    // -1048576 negates to itself; as an unsigned 21-bit magnitude it is 1048576
    // and therefore lands in the overflow range.
    always_comb begin
        mag_full = value_q[20] ? (~value_q + 21'd1) : value_q;
        ovf_c    = value_q[20] ? (mag_full > 21'd99999) : (mag_full > 21'd999999);
    end

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < 6; i++) begin
            if (bcd_sr[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            value_q  <= '0;
            mag      <= '0;
            bcd_sr   <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            BCD      <= '0;
            signBit  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        value_q <= value;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    sign_q <= value_q[20];
                    ovf_q  <= ovf_c;
                    mag    <= mag_full[19:0];
                    bcd_sr <= '0;
                    cnt    <= '0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    bcd_sr <= {bcd_adj[22:0], mag[19]};
                    mag    <= {mag[18:0], 1'b0};
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd19)
                        state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    if (ovf_q) begin
                        BCD      <= '0;
                        signBit  <= 1'b0;
                        overflow <= 1'b1;
                    end else begin
                        BCD      <= bcd_sr;
                        signBit  <= sign_q;
                        overflow <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_sequencer.sv
// Scoreboard bench: the driver pushes reference results computed with plain
// integer arithmetic; a negedge monitor pops and compares on every done pulse.
module tb_bcd_convert_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [20:0] value = '0;
    logic        busy;
    logic        done;
    logic [23:0] BCD;
    logic        signBit;
    logic        overflow;

    bcd_convert_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .BCD      (BCD),
        .signBit  (signBit),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] bcd;
        logic        sgn;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t last = '{bcd: 24'h0, sgn: 1'b0, ovf: 1'b0, cyc: 0};
    int   cyc = 0;
    int   free_cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic exp_t ref_model(input logic [20:0] v, input int done_at);
        exp_t e;
        int   s;
        int   m;
        int   p;
        s = {{11{v[20]}}, v};
        m = (s < 0) ? -s : s;
        e.cyc = done_at;
        if ((s < 0 && m > 99999) || (s >= 0 && m > 999999)) begin
            e.bcd = 24'h0;
            e.sgn = 1'b0;
            e.ovf = 1'b1;
        end else begin
            e.bcd = 24'h0;
            p = 1;
            for (int i = 0; i < 6; i++) begin
                e.bcd[i*4 +: 4] = 4'((m / p) % 10);
                p = p * 10;
            end
            e.sgn = (s < 0);
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("bcd", 32'(BCD), 32'(e.bcd));
                check("sign", 32'(signBit), 32'(e.sgn));
                check("overflow", 32'(overflow), 32'(e.ovf));
                check("busy_at_done", 32'(busy), 32'd0);
                last = e;
            end
        end else begin
            check("busy", 32'(busy), 32'(q.size() > 0));
            check("hold", {7'd0, overflow, signBit, BCD}, {7'd0, last.ovf, last.sgn, last.bcd});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [20:0] v, input bit repulse);
        int c0;
        while (cyc < free_cyc) step();
        start = 1'b1;
        value = v;
        step();
        c0 = cyc;
        q.push_back(ref_model(v, c0 + 22));
        free_cyc = c0 + 22;
        start = 1'b0;
        value = 21'($urandom);
        if (repulse) begin
            while (cyc < c0 + 4) step();
            start = 1'b1;
            value = 21'($urandom);
            step();
            start = 1'b0;
        end
    endtask

    logic [20:0] directed [10] = '{
        21'd123456, 21'h1FFFF9, 21'd999999, 21'd1000000, -21'sd99999,
        -21'sd100000, 21'h100000, 21'd0, 21'd1048575, 21'h1FFFFF
    };

    initial begin
        int c0;
        int gap;
        repeat (3) step();
        reset = 1'b0;
        step();

        convert(directed[0], 1'b1);
        for (int i = 1; i < 10; i++) convert(directed[i], 1'b0);

        // abort mid-conversion; reset also wins over a concurrent start
        while (cyc < free_cyc) step();
        start = 1'b1;
        value = 21'd4321;
        step();
        c0 = cyc;
        start = 1'b0;
        q.push_back(ref_model(21'd4321, c0 + 22));
        while (cyc < c0 + 9) step();
        reset = 1'b1;
        start = 1'b1;
        step();
        q.delete();
        last = '{bcd: 24'h0, sgn: 1'b0, ovf: 1'b0, cyc: 0};
        reset = 1'b0;
        start = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_outputs", {7'd0, overflow, signBit, BCD}, 32'd0);
        repeat (30) step();
        free_cyc = cyc;
        convert(-21'sd42, 1'b0);

        for (int i = 0; i < 30; i++) begin
            gap = $urandom_range(0, 3);
            free_cyc = free_cyc + gap;
            if (i % 3 == 0) convert(21'($urandom), 1'b0);
            else convert(21'($urandom_range(0, 2000000) - 1000000), (i % 5 == 1));
        end

        for (int i = 0; i < 60 && q.size() > 0; i++) step();
        if (q.size() > 0) check("drain_timeout", 32'(q.size()), 32'd0);
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
